// File: rtl/pixel_sink.sv
`default_nettype none
// ============================================================================
// Module   : pixel_sink
// Brief    : Buffers sprite pixels in a small FIFO and forwards them to a
//            framebuffer write port. Also runs a full-screen black clear
//            once any queued pixels have been flushed.
// Revision : 1.0 - initial release
// ============================================================================
module pixel_sink #(
  parameter int DEPTH = 8,
  parameter int X_MAX = 159,
  parameter int Y_MAX = 119
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       plot,
  input  logic [7:0] x,
  input  logic [6:0] y,
  input  logic [2:0] colour,
  output logic       in_ready,
  input  logic       clear_req,
  input  logic       vga_busy,
  output logic       vga_plot,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       clear_done,
  output logic       overflow,
  output logic       dropped,
  output logic [4:0] fill
);

  localparam int         PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0] DEPTH_F = 5'(DEPTH);
  localparam logic [7:0] XM      = 8'(X_MAX);
  localparam logic [6:0] YM      = 7'(Y_MAX);

  typedef enum logic [1:0] {
    DRAIN = 2'd0,
    FLUSH = 2'd1,
    CLEAR = 2'd2
  } state_t;

  state_t        state, state_next;
  logic [17:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [7:0]    sweep_x;
  logic [6:0]    sweep_y;

  logic in_range, push, pop, clr_wr, sweep_last;

  // Handshake and datapath qualifiers shared by the FIFO, FSM and output stage.
  always_comb begin
    in_ready   = (state == DRAIN) && (fill < DEPTH_F);
    in_range   = (x <= XM) && (y <= YM);
    push       = plot && in_ready && in_range;
    pop        = (state != CLEAR) && (fill != 5'd0) && !vga_busy;
    clr_wr     = (state == CLEAR) && !vga_busy;
    sweep_last = (sweep_x == XM) && (sweep_y == YM);
  end

  // FIFO storage; contents need no reset because fill gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {x, y, colour};
    end
  end

  // FIFO pointers and occupancy; power-of-two depth lets pointers wrap freely.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= 5'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fill <= fill + 5'd1;
        2'b01:   fill <= fill - 5'd1;
        default: fill <= fill;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= DRAIN;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; a clear only starts once the FIFO is (about to be) empty.
  always_comb begin
    state_next = state;
    case (state)
      DRAIN: begin
        if (clear_req) begin
          if ((fill == 5'd0) || ((fill == 5'd1) && pop)) begin
            state_next = CLEAR;
          end else begin
            state_next = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (pop && (fill == 5'd1)) begin
          state_next = CLEAR;
        end
      end
      CLEAR: begin
        if (clr_wr && sweep_last) begin
          state_next = DRAIN;
        end
      end
      default: state_next = DRAIN;
    endcase
  end

  // Clear sweep counters: x is the inner loop, held whenever the port is busy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sweep_x <= 8'd0;
      sweep_y <= 7'd0;
    end else if (clr_wr) begin
      if (sweep_x == XM) begin
        sweep_x <= 8'd0;
        sweep_y <= (sweep_y == YM) ? 7'd0 : sweep_y + 7'd1;
      end else begin
        sweep_x <= sweep_x + 8'd1;
      end
    end
  end

  // Registered framebuffer write port plus status pulses and sticky overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vga_plot   <= 1'b0;
      vga_x      <= 8'd0;
      vga_y      <= 7'd0;
      vga_colour <= 3'd0;
      clear_done <= 1'b0;
      dropped    <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      vga_plot   <= pop || clr_wr;
      clear_done <= clr_wr && sweep_last;
      dropped    <= plot && in_ready && !in_range;
      overflow   <= overflow || (plot && !in_ready);
      if (pop) begin
        {vga_x, vga_y, vga_colour} <= mem[rd_ptr];
      end else if (clr_wr) begin
        vga_x      <= sweep_x;
        vga_y      <= sweep_y;
        vga_colour <= 3'd0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pixel_sink.sv
`default_nettype none
// ============================================================================
// Module   : tb_pixel_sink
// Brief    : Scoreboard bench for pixel_sink. Expected framebuffer writes are
//            queued when stimulus is applied and compared as writes appear.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pixel_sink;

  logic       clk = 1'b0;
  logic       reset;
  logic       plot;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       in_ready;
  logic       clear_req;
  logic       vga_busy;
  logic       vga_plot;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       clear_done;
  logic       overflow;
  logic       dropped;
  logic [4:0] fill;

  int n_checks = 0;
  int n_errors = 0;
  int n_writes = 0;
  int n_clear  = 0;
  logic busy_at_edge = 1'b0;
  logic [17:0] exp_q[$];

  pixel_sink #(.DEPTH(8), .X_MAX(159), .Y_MAX(119)) dut (
    .clk(clk), .reset(reset), .plot(plot), .x(x), .y(y), .colour(colour),
    .in_ready(in_ready), .clear_req(clear_req), .vga_busy(vga_busy),
    .vga_plot(vga_plot), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .clear_done(clear_done), .overflow(overflow), .dropped(dropped), .fill(fill)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Busy level seen by the DUT at each active edge.
  always @(posedge clk) busy_at_edge <= vga_busy;

  // Scoreboard: every write must match the oldest expected pixel.
  always @(negedge clk) begin
    if (!reset) begin
      if (vga_plot) begin
        n_writes++;
        check_eq("write_while_busy", {31'd0, busy_at_edge}, 32'd0);
        if (exp_q.size() == 0) begin
          check_eq("unexpected_write", {14'd0, vga_x, vga_y, vga_colour}, 32'hFFFFFFFF);
        end else begin
          check_eq("write_data", {14'd0, vga_x, vga_y, vga_colour}, {14'd0, exp_q.pop_front()});
        end
      end
      if (clear_done) n_clear++;
    end
  end

  task automatic drive_plot(input logic [7:0] px, input logic [6:0] py, input logic [2:0] pc);
    plot = 1'b1; x = px; y = py; colour = pc;
  endtask

  task automatic idle_inputs();
    plot = 1'b0; x = 8'd0; y = 7'd0; colour = 3'd0;
  endtask

  task automatic push_sweep();
    for (int yy = 0; yy <= 119; yy++)
      for (int xx = 0; xx <= 159; xx++)
        exp_q.push_back({xx[7:0], yy[6:0], 3'b000});
  endtask

  task automatic wait_empty(input string tag, input int budget);
    int cnt = 0;
    while (exp_q.size() != 0 && cnt < budget) begin
      @(negedge clk);
      cnt++;
    end
    check_eq(tag, exp_q.size(), 32'd0);
  endtask

  initial begin
    int base;
    int cnt;
    reset = 1'b1; clear_req = 1'b0; vga_busy = 1'b0;
    idle_inputs();
    repeat (3) @(negedge clk);

    // Reset state.
    check_eq("rst_vga_plot", {31'd0, vga_plot}, 32'd0);
    check_eq("rst_vga_xyc", {14'd0, vga_x, vga_y, vga_colour}, 32'd0);
    check_eq("rst_flags", {29'd0, clear_done, overflow, dropped}, 32'd0);
    check_eq("rst_fill", {27'd0, fill}, 32'd0);
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
    reset = 1'b0;

    // Single pixel: write appears after the second edge, for one cycle.
    @(negedge clk);
    drive_plot(8'd45, 7'd45, 3'b101);
    exp_q.push_back({8'd45, 7'd45, 3'b101});
    @(negedge clk);
    idle_inputs();
    check_eq("single_not_yet", {31'd0, vga_plot}, 32'd0);
    @(negedge clk);
    check_eq("single_plot", {31'd0, vga_plot}, 32'd1);
    check_eq("single_data", {14'd0, vga_x, vga_y, vga_colour}, {14'd0, 8'd45, 7'd45, 3'b101});
    check_eq("single_fill", {27'd0, fill}, 32'd0);
    @(negedge clk);
    check_eq("single_one_cycle", {31'd0, vga_plot}, 32'd0);

    // Ten plots against a busy port: eight stored, two lost.
    vga_busy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("ovf_in_ready", {31'd0, in_ready}, (i < 8) ? 32'd1 : 32'd0);
      check_eq("ovf_flag", {31'd0, overflow}, (i >= 9) ? 32'd1 : 32'd0);
      drive_plot(8'(i * 3), 7'(i * 5), 3'(i));
      if (i < 8) exp_q.push_back({8'(i * 3), 7'(i * 5), 3'(i)});
    end
    @(negedge clk);
    idle_inputs();
    check_eq("ovf_fill", {27'd0, fill}, 32'd8);
    check_eq("ovf_sticky", {31'd0, overflow}, 32'd1);
    base = n_writes;
    vga_busy = 1'b0;
    wait_empty("ovf_drain", 30);
    repeat (3) @(negedge clk);
    check_eq("ovf_write_count", n_writes - base, 32'd8);
    check_eq("ovf_fill_empty", {27'd0, fill}, 32'd0);

    // Out-of-range pixels are discarded with a dropped pulse each.
    base = n_writes;
    @(negedge clk);
    drive_plot(8'd160, 7'd10, 3'b111);
    @(negedge clk);
    check_eq("drop_x", {31'd0, dropped}, 32'd1);
    drive_plot(8'd10, 7'd120, 3'b111);
    @(negedge clk);
    check_eq("drop_y", {31'd0, dropped}, 32'd1);
    idle_inputs();
    @(negedge clk);
    check_eq("drop_pulse_end", {31'd0, dropped}, 32'd0);
    repeat (3) @(negedge clk);
    check_eq("drop_fill", {27'd0, fill}, 32'd0);
    check_eq("drop_no_write", n_writes - base, 32'd0);

    // Three queued pixels then a clear: flush first, then the full sweep.
    vga_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive_plot(8'(100 + i), 7'(50 + i), 3'(i + 1));
      exp_q.push_back({8'(100 + i), 7'(50 + i), 3'(i + 1)});
    end
    @(negedge clk);
    idle_inputs();
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    check_eq("flush_in_ready", {31'd0, in_ready}, 32'd0);
    push_sweep();
    base = n_writes;
    vga_busy = 1'b0;
    cnt = 0;
    while (n_clear < 1 && cnt < 25000) begin
      @(negedge clk);
      cnt++;
    end
    repeat (4) @(negedge clk);
    check_eq("clr_done_count", n_clear, 32'd1);
    check_eq("clr_write_count", n_writes - base, 32'd19203);
    check_eq("clr_queue_empty", exp_q.size(), 32'd0);
    check_eq("clr_back_ready", {31'd0, in_ready}, 32'd1);

    // Clear from an empty FIFO with the port busy every other cycle.
    @(negedge clk);
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    push_sweep();
    base = n_writes;
    cnt = 0;
    while (n_clear < 2 && cnt < 50000) begin
      @(negedge clk);
      vga_busy = ~vga_busy;
      cnt++;
    end
    vga_busy = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("busy_clr_done", n_clear, 32'd2);
    check_eq("busy_clr_writes", n_writes - base, 32'd19200);
    check_eq("busy_clr_queue", exp_q.size(), 32'd0);

    // Reset in the middle of a clear abandons it without clear_done.
    @(negedge clk);
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    push_sweep();
    repeat (100) @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    exp_q.delete();
    check_eq("mid_rst_plot", {31'd0, vga_plot}, 32'd0);
    check_eq("mid_rst_xyc", {14'd0, vga_x, vga_y, vga_colour}, 32'd0);
    check_eq("mid_rst_flags", {29'd0, clear_done, overflow, dropped}, 32'd0);
    check_eq("mid_rst_fill", {27'd0, fill}, 32'd0);
    check_eq("mid_rst_drain", {31'd0, in_ready}, 32'd1);
    #2 reset = 1'b0;
    base = n_writes;
    repeat (5) @(negedge clk);
    check_eq("mid_rst_no_writes", n_writes - base, 32'd0);
    check_eq("mid_rst_no_done", n_clear, 32'd2);
    drive_plot(8'd7, 7'd8, 3'b011);
    exp_q.push_back({8'd7, 7'd8, 3'b011});
    @(negedge clk);
    idle_inputs();
    wait_empty("post_rst_write", 10);
    repeat (2) @(negedge clk);
    check_eq("post_rst_count", n_writes - base, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pixel_sink.md
PIXEL_SINK -- requirements
Module: pixel_sink

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter X_MAX, default 159, largest legal x.
REQ-003 SHALL have parameter Y_MAX, default 119, largest legal y.
REQ-004 Ports SHALL be as follows; there SHALL be one clock, and reset SHALL be asynchronous and active-high:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- plot  in  1  pixel write request from a sprite drawer.
- x  in  8  pixel x.
- y  in  7  pixel y.
- colour  in  3  pixel colour.
- in_ready  out  1  the sink can accept a pixel this cycle.
- clear_req  in  1  request a full-screen black clear.
- vga_busy  in  1  the framebuffer port cannot take a write this cycle.
- vga_plot  out  1  one-cycle framebuffer write strobe.
- vga_x  out  8  write x.
- vga_y  out  7  write y.
- vga_colour  out  3  write colour.
- clear_done  out  1  one-cycle pulse when a clear completes.
- overflow  out  1  sticky flag: a pixel was lost.
- dropped  out  1  one-cycle pulse: an out-of-range pixel was discarded.
- fill  out  5  current FIFO occupancy.

Function
REQ-005 The FSM SHALL have exactly three states: DRAIN, FLUSH and CLEAR.
REQ-006 in_ready SHALL be combinational and equal (state==DRAIN && fill<DEPTH).
REQ-007 On a rising edge with plot=1, in_ready=1 and x<=X_MAX and y<=Y_MAX, {x,y,colour} SHALL be pushed into the FIFO.
REQ-008 A plot with in_ready=1 and x>X_MAX or y>Y_MAX SHALL NOT be stored, and dropped SHALL pulse high for the following cycle.
REQ-009 A plot with in_ready=0 SHALL be discarded, and overflow SHALL set to 1 and remain 1 until reset.
REQ-010 In DRAIN or FLUSH, when fill>0 and vga_busy=0, the head entry SHALL be popped and registered onto vga_x/vga_y/vga_colour, with vga_plot=1 for exactly the next cycle.
REQ-011 vga_plot SHALL be 0 in every cycle after an edge where no write was issued; no write SHALL be issued while vga_busy=1.
REQ-012 Latency: a pixel pushed at edge N into an empty FIFO with vga_busy=0 SHALL appear with vga_plot=1 after edge N+1.
REQ-013 A push and a pop on the same edge SHALL leave fill unchanged.
REQ-014 A push and a pop on the same edge SHALL preserve FIFO order.
REQ-015 Pointers SHALL wrap modulo DEPTH.
REQ-016 DRAIN SHALL transition to FLUSH on clear_req=1 when fill>0.
REQ-017 DRAIN SHALL transition directly to CLEAR on clear_req=1 when fill==0, or when fill==1 and that entry pops on the same edge.
REQ-018 Any plot arriving on the same edge as clear_req SHALL obey REQ-007 through REQ-009 with DRAIN's in_ready.
REQ-019 FLUSH SHALL transition to CLEAR on the edge that pops the last entry.
REQ-020 CLEAR SHALL sweep x from 0 to X_MAX as the inner loop and y from 0 to Y_MAX as the outer loop, issuing colour 000 for each pixel.
REQ-021 CLEAR SHALL issue one write per cycle and SHALL hold the sweep counters while vga_busy=1.
REQ-022 After issuing (X_MAX,Y_MAX), CLEAR SHALL pulse clear_done for one cycle, reset the sweep counters to 0 and return to DRAIN.
REQ-023 clear_req SHALL be ignored in FLUSH and in CLEAR.
REQ-024 fill SHALL never exceed DEPTH.

Reset
REQ-025 While reset=1, the state SHALL be DRAIN and the FIFO SHALL be empty (fill=0).
REQ-026 While reset=1, vga_plot, clear_done, dropped and overflow SHALL be 0, vga_x/vga_y/vga_colour SHALL be 0, and the sweep counters SHALL be 0.
REQ-027 Reset asserted mid-FLUSH or mid-CLEAR SHALL abandon the operation with no clear_done pulse.

Verification
REQ-028 The bench SHALL cover: a single plot (45,45,101) with idle vga_busy -> after 2 edges, vga_plot=1 with (45,45,101) for one cycle, and fill returns to 0.
REQ-029 The bench SHALL cover: 10 consecutive plots with vga_busy=1 -> in_ready=0 after the 8th, overflow=1 after the 9th, fill=8; after releasing vga_busy, exactly 8 writes in push order.
REQ-030 The bench SHALL cover: plot (160,10) and plot (10,120) -> dropped pulses twice, no vga_plot, fill=0.
REQ-031 The bench SHALL cover: 3 queued pixels plus clear_req -> 3 writes (FLUSH), then 19200 writes of colour 000 from (0,0) to (159,119), then a single clear_done pulse.
REQ-032 The bench SHALL cover: vga_busy toggled every other cycle during CLEAR -> still exactly 19200 writes, each coordinate once, in order.
REQ-033 The bench SHALL cover: reset pulsed mid-CLEAR -> all outputs 0 and state DRAIN; a subsequent plot is written normally.
